// File: rtl/cpm_reg_pipe.sv
// cpm_reg_pipe: elastic DEPTH-stage pipeline register with valid/ready
// handshake, bubble collapsing, synchronous flush and occupancy count.
// Stage 0 faces the producer, stage DEPTH-1 drives the consumer.

// One pipeline stage: holds a valid bit and a data word, loads from
// upstream whenever the stage is allowed to move.
module cpm_reg_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Rstn,
  input  logic          clear,
  input  logic          load,
  input  logic          up_vld,
  input  logic [DW-1:0] up_dat,
  output logic          vld,
  output logic [DW-1:0] dat
);

  // Valid follows upstream when the stage moves; data only captured for real items
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (clear) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (load) begin
      vld <= up_vld;
      if (up_vld) dat <= up_dat;
    end
  end

endmodule

module cpm_reg_pipe #(
  parameter int DW    = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          Clk,
  input  logic          Rstn,
  input  logic          Clear,
  input  logic          InVld,
  output logic          InRdy,
  input  logic [DW-1:0] InData,
  output logic          OutVld,
  input  logic          OutRdy,
  output logic [DW-1:0] OutData,
  output logic [CW-1:0] Count
);

  logic [DEPTH-1:0]         vld;
  logic [DEPTH-1:0][DW-1:0] dat;
  logic [DEPTH-1:0]         rdy;
  logic                     in_xfer;
  logic                     out_xfer;

  // Ready ripples back from the consumer; an empty stage always accepts,
  // which is what lets bubbles collapse while the output is stalled.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = ~vld[DEPTH-1] | OutRdy;
    for (int i = DEPTH-2; i >= 0; i--)
      rdy[i] = ~vld[i] | rdy[i+1];
  end

  assign InRdy   = rdy[0] & ~Clear;
  assign OutVld  = vld[DEPTH-1] & ~Clear;
  assign OutData = dat[DEPTH-1];

  assign in_xfer  = InVld & InRdy;
  assign out_xfer = OutVld & OutRdy;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic          up_vld;
    logic [DW-1:0] up_dat;
    if (g == 0) begin : g_head
      assign up_vld = InVld;
      assign up_dat = InData;
    end else begin : g_body
      assign up_vld = vld[g-1];
      assign up_dat = dat[g-1];
    end
    cpm_reg_pipe_stage #(.DW(DW)) u_stage (
      .Clk    (Clk),
      .Rstn   (Rstn),
      .clear  (Clear),
      .load   (rdy[g]),
      .up_vld (up_vld),
      .up_dat (up_dat),
      .vld    (vld[g]),
      .dat    (dat[g])
    );
  end

  // Occupancy moves only on a lone accept or a lone emit; flush empties it
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn)
      Count <= '0;
    else if (Clear)
      Count <= '0;
    else if (in_xfer && !out_xfer)
      Count <= Count + CW'(1);
    else if (out_xfer && !in_xfer)
      Count <= Count - CW'(1);
  end

endmodule

// File: tb/tb_cpm_reg_pipe.sv
// Bench for cpm_reg_pipe: three configurations (D2/W8, D4/W8, D1/W16)
// checked against a queue model that tracks each item's stage position.
module tb_cpm_reg_pipe;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        clr  [3];
  logic        ivld [3];
  logic        ordy [3];
  logic [15:0] idat [3];
  logic        irdy [3];
  logic        ovld [3];
  logic [15:0] odat [3];
  logic [2:0]  cnt  [3];

  logic r0, r1, r2, v0, v1, v2;
  logic [7:0]  od0, od1;
  logic [15:0] od2;
  logic [1:0]  c0;
  logic [2:0]  c1;
  logic [0:0]  c2;

  cpm_reg_pipe #(.DW(8), .DEPTH(2)) u_d2 (
    .Clk(clk), .Rstn(rstn), .Clear(clr[0]), .InVld(ivld[0]), .InRdy(r0),
    .InData(idat[0][7:0]), .OutVld(v0), .OutRdy(ordy[0]), .OutData(od0), .Count(c0));
  cpm_reg_pipe #(.DW(8), .DEPTH(4)) u_d4 (
    .Clk(clk), .Rstn(rstn), .Clear(clr[1]), .InVld(ivld[1]), .InRdy(r1),
    .InData(idat[1][7:0]), .OutVld(v1), .OutRdy(ordy[1]), .OutData(od1), .Count(c1));
  cpm_reg_pipe #(.DW(16), .DEPTH(1)) u_d1 (
    .Clk(clk), .Rstn(rstn), .Clear(clr[2]), .InVld(ivld[2]), .InRdy(r2),
    .InData(idat[2]), .OutVld(v2), .OutRdy(ordy[2]), .OutData(od2), .Count(c2));

  assign irdy[0] = r0;  assign irdy[1] = r1;  assign irdy[2] = r2;
  assign ovld[0] = v0;  assign ovld[1] = v1;  assign ovld[2] = v2;
  assign odat[0] = {8'h00, od0};
  assign odat[1] = {8'h00, od1};
  assign odat[2] = od2;
  assign cnt[0]  = {1'b0, c0};
  assign cnt[1]  = c1;
  assign cnt[2]  = {2'b00, c2};

  typedef struct {
    logic [15:0] data;
    int          pos;
  } item_t;

  item_t       mq[$];
  logic [15:0] outs[$];
  int          cur, md, cyc_n, first_out;
  logic [15:0] mask;
  string       tag;
  int          total = 0;
  int          bad = 0;

  // Select a DUT, flush it without checking, and start with an empty model
  task automatic sel(input int idx, input string name);
    cur = idx;
    tag = name;
    md   = (idx == 0) ? 2 : (idx == 1) ? 4 : 1;
    mask = (idx == 2) ? 16'hFFFF : 16'h00FF;
    ivld[idx] = 1'b0; ordy[idx] = 1'b0; clr[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr[idx] = 1'b0;
    mq.delete();
    outs.delete();
    cyc_n = 0;
    first_out = -1;
  endtask

  // One clock cycle: drive, check against the model, then advance the model
  task automatic cyc(input bit v, input logic [15:0] d, input bit r, input bit c,
                     output bit acc);
    bit er, eo;
    int n, prev;
    logic [15:0] dm;
    dm = d & mask;
    ivld[cur] = v; idat[cur] = dm; ordy[cur] = r; clr[cur] = c;
    #1;
    n  = mq.size();
    er = ((n < md) || r) && !c;
    eo = (n > 0) && (mq[0].pos == md-1) && !c;
    total++;
    if (irdy[cur] !== er) begin
      bad++; $display("FAIL %s in_rdy cyc=%0d got=%b exp=%b", tag, cyc_n, irdy[cur], er);
    end
    total++;
    if (ovld[cur] !== eo) begin
      bad++; $display("FAIL %s out_vld cyc=%0d got=%b exp=%b", tag, cyc_n, ovld[cur], eo);
    end
    if (eo) begin
      total++;
      if (odat[cur] !== mq[0].data) begin
        bad++; $display("FAIL %s out_data cyc=%0d got=%h exp=%h", tag, cyc_n, odat[cur], mq[0].data);
      end
    end
    total++;
    if (cnt[cur] !== 3'(n)) begin
      bad++; $display("FAIL %s count cyc=%0d got=%0d exp=%0d", tag, cyc_n, cnt[cur], n);
    end
    if (ovld[cur] === 1'b1 && first_out < 0) first_out = cyc_n;
    if (ovld[cur] === 1'b1 && r) outs.push_back(odat[cur]);
    acc = v && er;
    @(posedge clk);
    if (c) mq.delete();
    else begin
      if (eo && r) void'(mq.pop_front());
      // each item steps forward unless the slot ahead is still taken
      prev = md;
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].pos + 1 < prev) mq[i].pos = mq[i].pos + 1;
        prev = mq[i].pos;
      end
      if (acc) mq.push_back('{data: dm, pos: 0});
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < md + 2; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0, a);
  endtask

  task automatic test_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ovld[k] !== 1'b0 || odat[k] !== 16'h0 || cnt[k] !== 3'd0 || irdy[k] !== 1'b1) begin
        bad++;
        $display("FAIL reset cfg%0d vld=%b data=%h cnt=%0d rdy=%b exp 0/0/0/1",
                 k, ovld[k], odat[k], cnt[k], irdy[k]);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    bit a;
    sel(0, "stream");
    cyc(1'b1, 16'h11, 1'b1, 1'b0, a);
    cyc(1'b1, 16'h22, 1'b1, 1'b0, a);
    cyc(1'b1, 16'h33, 1'b1, 1'b0, a);
    drain();
    total++;
    if (first_out != 2) begin
      bad++; $display("FAIL stream latency got=%0d exp=2", first_out);
    end
    total++;
    if (outs.size() != 3 || outs[0] !== 16'h11 || outs[1] !== 16'h22 || outs[2] !== 16'h33) begin
      bad++; $display("FAIL stream order got_n=%0d exp=3 (11,22,33)", outs.size());
    end
  endtask

  task automatic test_backpressure();
    bit a;
    sel(0, "bp");
    cyc(1'b1, 16'hA1, 1'b0, 1'b0, a);
    cyc(1'b1, 16'hA2, 1'b0, 1'b0, a);
    cyc(1'b1, 16'hA3, 1'b0, 1'b0, a);
    total++;
    if (a) begin bad++; $display("FAIL bp full_accept got=1 exp=0"); end
    cyc(1'b1, 16'hA3, 1'b1, 1'b0, a);
    total++;
    if (!a || outs.size() != 1 || outs[0] !== 16'hA1) begin
      bad++; $display("FAIL bp swap acc=%b emitted=%0d exp acc=1 emitted A1", a, outs.size());
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b0, a);
    drain();
  endtask

  task automatic test_bubble();
    bit a;
    sel(1, "bubble");
    cyc(1'b1, 16'hB0, 1'b0, 1'b0, a);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b0, 1'b0, a);
    for (int i = 1; i < 4; i++) begin
      cyc(1'b1, 16'hB0 + 16'(i), 1'b0, 1'b0, a);
      total++;
      if (!a) begin bad++; $display("FAIL bubble accept%0d got=0 exp=1", i); end
    end
    cyc(1'b1, 16'hBF, 1'b0, 1'b0, a);
    total++;
    if (a) begin bad++; $display("FAIL bubble full_accept got=1 exp=0"); end
    cyc(1'b0, 16'h0, 1'b0, 1'b0, a);
    drain();
  endtask

  task automatic test_clear();
    bit a;
    sel(0, "clear");
    cyc(1'b1, 16'hC1, 1'b0, 1'b0, a);
    cyc(1'b1, 16'hC2, 1'b0, 1'b0, a);
    cyc(1'b1, 16'hC3, 1'b1, 1'b1, a);
    total++;
    if (odat[cur] !== 16'h0) begin
      bad++; $display("FAIL clear out_data got=%h exp=0", odat[cur]);
    end
    cyc(1'b1, 16'hC4, 1'b1, 1'b0, a);
    first_out = -1; cyc_n = 0;
    drain();
    total++;
    if (first_out != 1 || outs.size() != 1 || outs[0] !== 16'hC4) begin
      bad++; $display("FAIL clear after first=%0d n=%0d exp first=1 n=1 C4", first_out, outs.size());
    end
  endtask

  task automatic test_reset_mid();
    bit a;
    sel(0, "rst_mid");
    cyc(1'b1, 16'hD1, 1'b0, 1'b0, a);
    cyc(1'b1, 16'hD2, 1'b0, 1'b0, a);
    ivld[cur] = 1'b0;
    #1 rstn = 1'b0;
    #1;
    total++;
    if (ovld[cur] !== 1'b0 || odat[cur] !== 16'h0 || cnt[cur] !== 3'd0) begin
      bad++; $display("FAIL rst_mid vld=%b data=%h cnt=%0d exp 0/0/0", ovld[cur], odat[cur], cnt[cur]);
    end
    #1 rstn = 1'b1;
    @(negedge clk);
    mq.delete();
    outs.delete();
    cyc(1'b1, 16'hE1, 1'b1, 1'b0, a);
    drain();
    total++;
    if (outs.size() != 1 || outs[0] !== 16'hE1) begin
      bad++; $display("FAIL rst_mid after n=%0d exp 1 item E1", outs.size());
    end
  endtask

  task automatic test_d1();
    bit a;
    logic [15:0] nxt;
    sel(2, "d1");
    nxt = 16'h0001;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b1, nxt, (i % 2) == 0, 1'b0, a);
      if (a) nxt++;
    end
    cyc(1'b0, 16'h0, 1'b1, 1'b0, a);
    drain();
    total++;
    if (outs.size() != int'(nxt) - 1) begin
      bad++; $display("FAIL d1 n_out got=%0d exp=%0d", outs.size(), int'(nxt) - 1);
    end
    for (int k = 0; k < outs.size(); k++) begin
      total++;
      if (outs[k] !== 16'(k + 1)) begin
        bad++; $display("FAIL d1 seq idx=%0d got=%h exp=%h", k, outs[k], 16'(k + 1));
      end
    end
  endtask

  task automatic test_random();
    bit a, v, pend;
    logic [15:0] d;
    for (int k = 0; k < 3; k++) begin
      sel(k, "random");
      pend = 1'b0; d = 16'h0; v = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (!pend) begin
          v = ($urandom_range(0, 3) != 0);
          d = 16'($urandom);
        end
        if ($urandom_range(0, 24) == 0) begin
          cyc(v, d, $urandom_range(0, 1) == 1, 1'b1, a);
          pend = 1'b0;
        end else begin
          cyc(v, d, $urandom_range(0, 2) != 0, 1'b0, a);
          pend = v && !a;
        end
      end
      drain();
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      clr[k] = 1'b0; ivld[k] = 1'b0; ordy[k] = 1'b0; idat[k] = 16'h0;
    end
    cur = 0; md = 2; mask = 16'hFF; cyc_n = 0; first_out = -1; tag = "init";
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_clear();
    test_reset_mid();
    test_d1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
